// File: rtl/coord_packet_rx.sv
// UART receiver and [HEADER][X][Y] packet parser: recovers 8N1 bytes, validates framing
// and coordinate range, and presents the last good X/Y pair with a one-cycle strobe.
module coord_packet_rx #(
    parameter int          CLKS_PER_BIT   = 10417,
    parameter logic [7:0]  HEADER         = 8'hFF,
    parameter int          MAX_COORD      = 15,
    parameter int          TIMEOUT_CYCLES = 200000,
    parameter int          ALIVE_CYCLES   = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_serial,
    output logic [7:0]  coord_x,
    output logic [7:0]  coord_y,
    output logic        coord_valid,
    output logic        frame_err,
    output logic        pkt_err,
    output logic [15:0] pkt_count,
    output logic        link_alive
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW   = $clog2(ALIVE_CYCLES + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_HDR, P_X, P_Y} p_state_t;

    logic            r_rst_meta, r_rst_n;
    logic            r_sync1, r_sync2, r_sync3;
    rx_state_t       r_rx_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_frame_err;
    p_state_t        r_p_state;
    logic [7:0]      r_x_tmp;
    logic [7:0]      r_coord_x, r_coord_y;
    logic            r_coord_valid, r_pkt_err;
    logic [15:0]     r_pkt_count;
    logic [TW-1:0]   r_to_cnt;
    logic [AW-1:0]   r_alive_cnt;

    logic            w_rx, w_fall, w_tick, w_byte_done, w_stop_bad;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rx        = r_sync2;
    assign w_fall      = r_sync3 & ~r_sync2;
    assign w_tick      = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_byte_done = (r_rx_state == RX_STOP) && w_tick && w_rx;
    assign w_stop_bad  = (r_rx_state == RX_STOP) && w_tick && !w_rx;

    // After a bad stop bit the FSM idles with the line low; w_fall cannot fire
    // until the line has gone high again, which gives the wait-for-idle behaviour.
    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_rx_state  <= RX_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            case (r_rx_state)
                RX_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_fall) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_clk_cnt == CW'(HALF - 1)) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Parser; a framing error outranks everything, a received byte outranks the timeout.
    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_p_state     <= P_HDR;
            r_x_tmp       <= '0;
            r_coord_x     <= '0;
            r_coord_y     <= '0;
            r_coord_valid <= 1'b0;
            r_pkt_err     <= 1'b0;
            r_pkt_count   <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_coord_valid <= 1'b0;
            r_pkt_err     <= 1'b0;
            if (w_stop_bad) begin
                r_p_state <= P_HDR;
                r_to_cnt  <= '0;
            end else if (w_byte_done) begin
                r_to_cnt <= '0;
                case (r_p_state)
                    P_HDR: begin
                        if (r_shift == HEADER) r_p_state <= P_X;
                    end
                    P_X: begin
                        if (r_shift == HEADER) begin
                            r_pkt_err <= 1'b1;
                        end else if (r_shift > 8'(MAX_COORD)) begin
                            r_pkt_err <= 1'b1;
                            r_p_state <= P_HDR;
                        end else begin
                            r_x_tmp   <= r_shift;
                            r_p_state <= P_Y;
                        end
                    end
                    P_Y: begin
                        if (r_shift == HEADER) begin
                            r_pkt_err <= 1'b1;
                            r_p_state <= P_X;
                        end else if (r_shift > 8'(MAX_COORD)) begin
                            r_pkt_err <= 1'b1;
                            r_p_state <= P_HDR;
                        end else begin
                            r_coord_x     <= r_x_tmp;
                            r_coord_y     <= r_shift;
                            r_coord_valid <= 1'b1;
                            r_pkt_count   <= r_pkt_count + 16'd1;
                            r_p_state     <= P_HDR;
                        end
                    end
                    default: r_p_state <= P_HDR;
                endcase
            end else if (r_p_state != P_HDR) begin
                if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_pkt_err <= 1'b1;
                    r_p_state <= P_HDR;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_alive_cnt <= '0;
        end else if (r_coord_valid) begin
            r_alive_cnt <= AW'(ALIVE_CYCLES);
        end else if (r_alive_cnt != '0) begin
            r_alive_cnt <= r_alive_cnt - 1'b1;
        end
    end

    assign coord_x     = r_coord_x;
    assign coord_y     = r_coord_y;
    assign coord_valid = r_coord_valid;
    assign frame_err   = r_frame_err;
    assign pkt_err     = r_pkt_err;
    assign pkt_count   = r_pkt_count;
    assign link_alive  = (r_alive_cnt != '0);

endmodule

// File: tb/tb_coord_packet_rx.sv
// Directed bench for coord_packet_rx: table of single frames plus hand-written
// sequences for back-to-back, resync, framing error, glitch, timeout and reset cases.
module tb_coord_packet_rx;

    localparam int CPB = 16;
    localparam int TO  = 1000;
    localparam int AL  = 5000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_serial = 1'b1;
    logic [7:0]  coord_x, coord_y;
    logic        coord_valid, frame_err, pkt_err, link_alive;
    logic [15:0] pkt_count;

    coord_packet_rx #(
        .CLKS_PER_BIT  (CPB),
        .HEADER        (8'hFF),
        .MAX_COORD     (15),
        .TIMEOUT_CYCLES(TO),
        .ALIVE_CYCLES  (AL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_serial  (rx_serial),
        .coord_x    (coord_x),
        .coord_y    (coord_y),
        .coord_valid(coord_valid),
        .frame_err  (frame_err),
        .pkt_err    (pkt_err),
        .pkt_count  (pkt_count),
        .link_alive (link_alive)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;
    int n_valid = 0, n_pkt = 0, n_frm = 0, n_viol = 0;
    logic [15:0] cap_q[$];
    logic prev_v = 1'b0, prev_p = 1'b0, prev_f = 1'b0;
    logic [7:0] px = 8'h00, py = 8'h00;

    // Event monitor: counts strobes, captures packets, flags wide strobes,
    // coincident error strobes and coordinate changes without coord_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (coord_valid) begin
                n_valid++;
                cap_q.push_back({coord_x, coord_y});
            end
            if (pkt_err) n_pkt++;
            if (frame_err) n_frm++;
            if ((coord_valid && prev_v) || (pkt_err && prev_p) || (frame_err && prev_f) ||
                (pkt_err && frame_err))
                n_viol++;
            if (!coord_valid && (coord_x != px || coord_y != py)) n_viol++;
        end
        prev_v = coord_valid;
        prev_p = pkt_err;
        prev_f = frame_err;
        px = coord_x;
        py = coord_y;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2;
        int          d_valid, d_pkt;
        logic [7:0]  ex, ey;
        logic [15:0] cnt;
        logic        alive;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int v0, p0, f0, k;
        logic [7:0] x, y;
        logic [15:0] exp_q[$];

        tbl[0] = '{8'hFF, 8'h05, 8'h0A, 1, 0, 8'h05, 8'h0A, 16'd1, 1'b1};
        tbl[1] = '{8'hFF, 8'h10, 8'h02, 0, 1, 8'h05, 8'h0A, 16'd1, 1'b1};
        tbl[2] = '{8'hFF, 8'h00, 8'h0F, 1, 0, 8'h00, 8'h0F, 16'd2, 1'b1};
        tbl[3] = '{8'hFF, 8'h0F, 8'h10, 0, 1, 8'h00, 8'h0F, 16'd2, 1'b1};
        tbl[4] = '{8'hFF, 8'h0F, 8'h00, 1, 0, 8'h0F, 8'h00, 16'd3, 1'b1};
        tbl[5] = '{8'h0A, 8'h0B, 8'h0C, 0, 0, 8'h0F, 8'h00, 16'd3, 1'b1};
        tbl[6] = '{8'hFF, 8'h0E, 8'h0D, 1, 0, 8'h0E, 8'h0D, 16'd4, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_coord_x", 32'(coord_x), 32'h0);
        check("rst_coord_y", 32'(coord_y), 32'h0);
        check("rst_strobes", 32'({coord_valid, frame_err, pkt_err}), 32'h0);
        check("rst_pkt_count", 32'(pkt_count), 32'h0);
        check("rst_link_alive", 32'(link_alive), 32'h0);

        // Single frames from the table, with a short idle gap after each.
        for (int i = 0; i < 7; i++) begin
            v0 = n_valid; p0 = n_pkt; f0 = n_frm;
            send_byte(tbl[i].b0, 1'b1);
            send_byte(tbl[i].b1, 1'b1);
            send_byte(tbl[i].b2, 1'b1);
            idle(3 * CPB);
            $display("tbl%0d: bytes %02h %02h %02h -> x=%02h y=%02h cnt=%0d", i,
                     tbl[i].b0, tbl[i].b1, tbl[i].b2, coord_x, coord_y, pkt_count);
            check($sformatf("tbl%0d_valid", i), n_valid - v0, tbl[i].d_valid);
            check($sformatf("tbl%0d_pkt_err", i), n_pkt - p0, tbl[i].d_pkt);
            check($sformatf("tbl%0d_frame_err", i), n_frm - f0, 0);
            check($sformatf("tbl%0d_x", i), 32'(coord_x), 32'(tbl[i].ex));
            check($sformatf("tbl%0d_y", i), 32'(coord_y), 32'(tbl[i].ey));
            check($sformatf("tbl%0d_count", i), 32'(pkt_count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_alive", i), 32'(link_alive), 32'(tbl[i].alive));
        end

        // 100 back-to-back frames, no idle gap.
        do_reset();
        cap_q.delete();
        v0 = n_valid; p0 = n_pkt;
        for (int i = 0; i < 100; i++) begin
            x = 8'(i % 16);
            y = 8'((i * 5 + 3) % 16);
            exp_q.push_back({x, y});
            send_byte(8'hFF, 1'b1);
            send_byte(x, 1'b1);
            send_byte(y, 1'b1);
        end
        idle(3 * CPB);
        $display("b2b: %0d packets captured, pkt_count=%0d", cap_q.size(), pkt_count);
        check("b2b_valid_count", n_valid - v0, 100);
        check("b2b_pkt_err", n_pkt - p0, 0);
        check("b2b_pkt_count", 32'(pkt_count), 32'd100);
        for (int i = 0; i < cap_q.size() && i < 100; i++)
            check($sformatf("b2b_pkt%0d", i), 32'(cap_q[i]), 32'(exp_q[i]));

        // Header inside a frame resynchronises.
        v0 = n_valid; p0 = n_pkt;
        send_byte(8'hFF, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'hFF, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'h09, 1'b1);
        idle(3 * CPB);
        $display("resync: x=%02h y=%02h", coord_x, coord_y);
        check("resync_pkt_err", n_pkt - p0, 1);
        check("resync_valid", n_valid - v0, 1);
        check("resync_xy", 32'({coord_x, coord_y}), 32'h0709);

        // Stop bit low, then a good frame.
        v0 = n_valid; p0 = n_pkt; f0 = n_frm;
        send_byte(8'h55, 1'b0);
        idle(2 * CPB);
        send_byte(8'hFF, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        idle(3 * CPB);
        $display("frame_err: frm=%0d x=%02h y=%02h", n_frm - f0, coord_x, coord_y);
        check("ferr_frame_err", n_frm - f0, 1);
        check("ferr_pkt_err", n_pkt - p0, 0);
        check("ferr_valid", n_valid - v0, 1);
        check("ferr_xy", 32'({coord_x, coord_y}), 32'h0102);

        // Framing error mid-frame forces header hunt without pkt_err.
        v0 = n_valid; p0 = n_pkt; f0 = n_frm;
        send_byte(8'hFF, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h20, 1'b0);
        idle(2 * CPB);
        send_byte(8'h07, 1'b1); send_byte(8'h09, 1'b1);
        idle(3 * CPB);
        $display("mid ferr: frm=%0d pkt=%0d valid=%0d", n_frm - f0, n_pkt - p0, n_valid - v0);
        check("midferr_frame_err", n_frm - f0, 1);
        check("midferr_pkt_err", n_pkt - p0, 0);
        check("midferr_valid", n_valid - v0, 0);
        check("midferr_xy_hold", 32'({coord_x, coord_y}), 32'h0102);

        // Short low glitch on an idle line.
        v0 = n_valid; p0 = n_pkt; f0 = n_frm;
        rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        $display("glitch: strobes=%0d", (n_valid - v0) + (n_pkt - p0) + (n_frm - f0));
        check("glitch_strobes", (n_valid - v0) + (n_pkt - p0) + (n_frm - f0), 0);

        // Inter-byte timeout.
        v0 = n_valid;
        send_byte(8'hFF, 1'b1); send_byte(8'h04, 1'b1);
        k = 1;
        while (k <= 1200) begin
            @(negedge clk);
            if (pkt_err) break;
            k++;
        end
        $display("timeout: pkt_err %0d cycles after X byte", k);
        check("timeout_window", 32'(k >= 985 && k <= 1005), 32'd1);
        check("timeout_no_valid", n_valid - v0, 0);
        check("timeout_count_hold", 32'(pkt_count), 32'd102);

        // Reset in the middle of the X byte.
        idle(2 * CPB);
        send_byte(8'hFF, 1'b1);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("midreset: x=%02h y=%02h cnt=%0d", coord_x, coord_y, pkt_count);
        check("midrst_xy", 32'({coord_x, coord_y}), 32'h0);
        check("midrst_count", 32'(pkt_count), 32'h0);
        check("midrst_strobes", 32'({coord_valid, frame_err, pkt_err, link_alive}), 32'h0);
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        rst_n = 1'b1;
        idle(2 * CPB);
        v0 = n_valid; p0 = n_pkt; f0 = n_frm;
        send_byte(8'hFF, 1'b1); send_byte(8'h0B, 1'b1); send_byte(8'h0C, 1'b1);
        idle(3 * CPB);
        $display("post reset frame: x=%02h y=%02h cnt=%0d", coord_x, coord_y, pkt_count);
        check("postrst_valid", n_valid - v0, 1);
        check("postrst_errs", (n_pkt - p0) + (n_frm - f0), 0);
        check("postrst_xy", 32'({coord_x, coord_y}), 32'h0B0C);
        check("postrst_count", 32'(pkt_count), 32'd1);
        check("postrst_alive", 32'(link_alive), 32'd1);

        // link_alive window boundaries.
        idle(4800);
        $display("alive @~4850: %0d", link_alive);
        check("alive_before_expiry", 32'(link_alive), 32'd1);
        idle(300);
        $display("alive @~5150: %0d", link_alive);
        check("alive_after_expiry", 32'(link_alive), 32'd0);

        check("strobe_protocol_violations", n_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
